euros_para_centimos: RTL and testbench



---
 rtl/euros_para_centimos.sv | 172 +++++++++++++++++
 tb/tb_euros_para_centimos.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/euros_para_centimos.sv
// euros_para_centimos
// Sequential euro -> centimos converter for the balanca price datapath.
// Result = euros_inteiro * 100 + euros_fracao. The multiply is a serial
// shift-add over the constant 100, one constant bit per clock (LSB first).
// After the add, the result is range-checked against 2^W-1.
// One request at a time through a start/busy/done handshake.
// The last result and its flags are held until the next completion.
//
// Optional build macro: EUROS_CENTIMOS_SAT_EN
//   defined   -> an out-of-range result saturates centimos to 2^W-1
//   undefined -> an out-of-range result wraps modulo 2^W
// The overflow flag behaves the same in both builds.
module euros_para_centimos #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] euros_inteiro,
  input  logic [W-1:0] euros_fracao,
  output logic [W-1:0] centimos,
  output logic         busy,
  output logic         done,
  output logic         erro,
  output logic         overflow
);

  // Accumulator headroom: 100 < 2^7, so 7 extra bits hold 100*(2^W-1)+99.
  localparam int AW = W + 7;

  // Constant multiplier. The top bit is padding so that every 3-bit
  // counter value indexes a real bit.
  localparam logic [7:0] MULT_K = 8'd100;

  // Largest legal cents fraction.
  localparam logic [W-1:0] FRAC_MAX = W'(99);

  // Index of the last constant bit processed in MULT.
  localparam logic [2:0] LAST_BIT = 3'd6;

`ifdef EUROS_CENTIMOS_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    SOMA = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   inteiro_q, inteiro_d;
  logic [W-1:0]   fracao_q, fracao_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [W-1:0]   centimos_q, centimos_d;
  logic           done_q, done_d;
  logic           erro_q, erro_d;
  logic           overflow_q, overflow_d;

  logic [AW-1:0]  addend;
  logic [AW-1:0]  sum;

  // True when the wide sum does not fit in W bits.
  function automatic logic out_of_range(input logic [AW-1:0] value);
    return |value[AW-1:W];
  endfunction

  // Narrow the wide sum to W bits. The build decides between clamping to
  // full scale and plain truncation.
  function automatic logic [W-1:0] fit_result(input logic [AW-1:0] value,
                                              input bit            sat_en);
    if (sat_en && out_of_range(value)) begin
      return {W{1'b1}};
    end
    return value[W-1:0];
  endfunction

  // Partial product for the current constant bit.
  assign addend = {{(AW-W){1'b0}}, inteiro_q} << cnt_q;

  // Final sum. It cannot wrap at AW bits: the largest value is 100*(2^W-1)+99.
  assign sum = acc_q + {{(AW-W){1'b0}}, fracao_q};

  // State and datapath registers; reset aborts any running conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      inteiro_q  <= '0;
      fracao_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      centimos_q <= '0;
      done_q     <= 1'b0;
      erro_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inteiro_q  <= inteiro_d;
      fracao_q   <= fracao_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      centimos_q <= centimos_d;
      done_q     <= done_d;
      erro_q     <= erro_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic: latch in IDLE, shift-add in MULT, add fraction and range-check in SOMA.
  always_comb begin
    state_d    = state_q;
    inteiro_d  = inteiro_q;
    fracao_d   = fracao_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    centimos_d = centimos_q;
    done_d     = 1'b0;
    erro_d     = erro_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          inteiro_d = euros_inteiro;
          fracao_d  = euros_fracao;
          acc_d     = '0;
          cnt_d     = '0;
          if (euros_fracao > FRAC_MAX) begin
            // A bad fraction completes at once. The previous centimos value is kept.
            erro_d     = 1'b1;
            overflow_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            state_d = MULT;
          end
        end
      end

      MULT: begin
        if (MULT_K[cnt_q]) begin
          acc_d = acc_q + addend;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_BIT) begin
          state_d = SOMA;
        end
      end

      SOMA: begin
        overflow_d = out_of_range(sum);
        erro_d     = 1'b0;
        centimos_d = fit_result(sum, SAT_EN);
        done_d     = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign centimos = centimos_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign erro     = erro_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_euros_para_centimos.sv
// Directed bench for euros_para_centimos.
// Expected results come from an arithmetic reference model. They are queued
// when a request is accepted and popped when done is seen.
module tb_euros_para_centimos;

  localparam int W = 14;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] euros_inteiro;
  logic [W-1:0] euros_fracao;
  logic [W-1:0] centimos;
  logic         busy;
  logic         done;
  logic         erro;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] c;
    logic         e;
    logic         o;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  euros_para_centimos #(.W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .euros_inteiro (euros_inteiro),
    .euros_fracao  (euros_fracao),
    .centimos      (centimos),
    .busy          (busy),
    .done          (done),
    .erro          (erro),
    .overflow      (overflow)
  );

  // Reference model. The price is computed at full integer precision.
  function automatic exp_t model(input int inteiro, input int fracao,
                                 input logic [W-1:0] prev_c);
    exp_t r;
    int   v;
    if (fracao > 99) begin
      r.c = prev_c;
      r.e = 1'b1;
      r.o = 1'b0;
      return r;
    end
    v   = inteiro * 100 + fracao;
    r.e = 1'b0;
    r.o = (v > MAXV);
`ifdef EUROS_CENTIMOS_SAT_EN
    r.c = r.o ? W'(MAXV) : W'(v);
`else
    r.c = W'(v % (MAXV + 1));
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Issue one request, then follow it to completion against the scoreboard.
  task automatic do_conv(input int inteiro, input int fracao, input string tag);
    int   n;
    bit   valid;
    exp_t e;
    valid         = (fracao <= 99);
    euros_inteiro = W'(inteiro);
    euros_fracao  = W'(fracao);
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(model(inteiro, fracao, centimos));
    n = 0;
    if (valid) begin
      chk({tag, "_busy_after_accept"}, busy, 1);
      for (n = 1; n <= 12; n++) begin
        @(posedge clk); #1;
        if (done) break;
        if (!busy) break;
      end
      chk({tag, "_latency"}, n, 8);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_centimos"}, centimos, e.c);
      chk({tag, "_erro"}, erro, e.e);
      chk({tag, "_overflow"}, overflow, e.o);
    end
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int ndone;
    int first_idx;
    int second_idx;

    rst           = 1'b1;
    start         = 1'b0;
    euros_inteiro = '0;
    euros_fracao  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_centimos", centimos, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_erro", erro, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic conversions and in-range boundary.
    do_conv(4, 70, "c470");
    do_conv(0, 0, "zero");
    do_conv(163, 83, "fullscale");
    // Overflow: just past full scale, then the largest operands.
    do_conv(163, 84, "ovf_edge");
    do_conv(16383, 99, "ovf_max");

    // Bad fraction: completes in one cycle, centimos is kept, busy never rises.
    do_conv(4, 70, "pre_err");
    do_conv(4, 100, "bad_frac");
    chk("bad_frac_busy_stays_low", busy, 0);
    do_conv(12, 34, "clear_err");

    // Start held high; operands change mid-run.
    ndone      = 0;
    first_idx  = -1;
    second_idx = -1;
    euros_inteiro = W'(5);
    euros_fracao  = W'(1);
    start         = 1'b1;
    @(posedge clk); #1;
    sb.push_back(model(5, 1, centimos));
    chk("hold_busy_k", busy, 1);
    for (int idx = 1; idx <= 17; idx++) begin
      if (idx == 2) begin
        euros_inteiro = W'(7);
        euros_fracao  = W'(2);
      end
      if (idx == 12) begin
        euros_inteiro = W'(9);
        euros_fracao  = W'(9);
      end
      @(posedge clk); #1;
      if (idx == 9) begin
        chk("hold_accept_k9", busy, 1);
        sb.push_back(model(7, 2, centimos));
      end
      if (done) begin
        ndone++;
        if (first_idx < 0) first_idx = idx;
        else second_idx = idx;
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          chk("hold_centimos", centimos, cur.c);
        end
      end
    end
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("hold_num_done", ndone, 2);
    chk("hold_first_done_edge", first_idx, 8);
    chk("hold_second_done_edge", second_idx, 17);
    chk("hold_busy_end", busy, 0);

    // Reset in the middle of MULT.
    euros_inteiro = W'(50);
    euros_fracao  = W'(50);
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_centimos", centimos, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_erro", erro, 0);
    chk("abort_overflow", overflow, 0);
    ndone = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_conv(21, 5, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
